fft_mag_peak: RTL and testbench

FFT_MAG_PEAK -- requirements
Module: fft_mag_peak

---
 rtl/fft_mag_peak.sv | 167 ++++++++++++++++
 tb/tb_fft_mag_peak.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_mag_peak.sv
// Streaming FFT magnitude estimator (max + min/2) with per-frame peak search
// over a configurable bin window, started on request and aligned to bin 0.
`timescale 1ns/1ps
module fft_mag_peak #(
  parameter int unsigned FFT_LEN   = 1024,
  parameter int unsigned SEARCH_LO = 1,
  parameter int unsigned SEARCH_HI = FFT_LEN/2 - 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] fft_real,
  input  logic [15:0] fft_imag,
  input  logic [15:0] fft_index,
  input  logic [7:0]  blk_exp,
  input  logic        source_valid,
  output logic        mag_valid,
  output logic [15:0] mag_data,
  output logic [15:0] mag_index,
  output logic        busy,
  output logic        done,
  output logic [15:0] peak_index,
  output logic [15:0] peak_mag,
  output logic [7:0]  peak_exp,
  output logic        frame_err
);

  localparam int unsigned DW = 16;
  localparam int unsigned IW = 16;
  localparam int unsigned AW = 17;
  localparam int unsigned EW = 8;

  localparam logic [IW-1:0] LAST_IDX = IW'(FFT_LEN - 1);
  localparam logic [IW-1:0] LO_IDX   = IW'(SEARCH_LO);
  localparam logic [IW-1:0] HI_IDX   = IW'(SEARCH_HI);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACCUM, DONE} state_t;

  state_t state;

  // Stage 1: absolute values widened by one bit so that -32768 maps to 32768.
  logic signed [AW-1:0] re_ext_c, im_ext_c;
  logic [AW-1:0]        abs_re_c, abs_im_c;
  logic [AW-1:0]        abs_re, abs_im;
  logic [IW-1:0]        idx1;
  logic [EW-1:0]        exp1;
  logic                 vld1;

  assign re_ext_c = {fft_real[15], fft_real};
  assign im_ext_c = {fft_imag[15], fft_imag};
  assign abs_re_c = re_ext_c[AW-1] ? AW'(-re_ext_c) : AW'(re_ext_c);
  assign abs_im_c = im_ext_c[AW-1] ? AW'(-im_ext_c) : AW'(im_ext_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1   <= 1'b0;
      abs_re <= '0;
      abs_im <= '0;
      idx1   <= '0;
      exp1   <= '0;
    end else begin
      vld1 <= source_valid;
      if (source_valid) begin
        abs_re <= abs_re_c;
        abs_im <= abs_im_c;
        idx1   <= fft_index;
        exp1   <= blk_exp;
      end
    end
  end

  // Stage 2: max + min/2; worst case 32768 + 16384 still fits in 16 bits.
  logic [AW-1:0] big_c, small_c, sum_c;
  logic [EW-1:0] exp2;

  assign big_c   = (abs_re >= abs_im) ? abs_re : abs_im;
  assign small_c = (abs_re >= abs_im) ? abs_im : abs_re;
  assign sum_c   = big_c + (small_c >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_valid <= 1'b0;
      mag_data  <= '0;
      mag_index <= '0;
      exp2      <= '0;
    end else begin
      mag_valid <= vld1;
      if (vld1) begin
        mag_data  <= DW'(sum_c);
        mag_index <= idx1;
        exp2      <= exp1;
      end
    end
  end

  // Peak search control, driven from the aligned magnitude stream.
  logic          sof_c, last_c, in_range_c, better_c;
  logic [DW-1:0] run_mag;
  logic [IW-1:0] run_idx;
  logic [EW-1:0] run_exp;

  assign sof_c      = mag_valid && (mag_index == '0);
  assign last_c     = mag_valid && (mag_index == LAST_IDX);
  assign in_range_c = (mag_index >= LO_IDX) && (mag_index <= HI_IDX);
  assign better_c   = mag_valid && in_range_c && (mag_data > run_mag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      frame_err  <= 1'b0;
      run_mag    <= '0;
      run_idx    <= '0;
      run_exp    <= '0;
      peak_index <= '0;
      peak_mag   <= '0;
      peak_exp   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= WAIT_SOF;
            busy      <= 1'b1;
            frame_err <= 1'b0;
          end
        end
        WAIT_SOF: begin
          if (sof_c) begin
            state   <= ACCUM;
            run_mag <= '0;
            run_idx <= LO_IDX;
            run_exp <= exp2;
          end
        end
        ACCUM: begin
          if (sof_c) begin
            // A new bin 0 mid-frame restarts the search on the new frame.
            frame_err <= 1'b1;
            run_mag   <= '0;
            run_idx   <= LO_IDX;
            run_exp   <= exp2;
          end else begin
            if (better_c) begin
              run_mag <= mag_data;
              run_idx <= mag_index;
            end
            if (last_c) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          peak_index <= run_idx;
          peak_mag   <= run_mag;
          peak_exp   <= run_exp;
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_mag_peak.sv
// Scoreboard bench for fft_mag_peak: directed frames push expected magnitude
// beats and peak results; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_fft_mag_peak;

  localparam int unsigned FFT_LEN = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] fft_real = '0;
  logic [15:0] fft_imag = '0;
  logic [15:0] fft_index = '0;
  logic [7:0]  blk_exp = '0;
  logic        source_valid = 1'b0;
  logic        mag_valid;
  logic [15:0] mag_data;
  logic [15:0] mag_index;
  logic        busy;
  logic        done;
  logic [15:0] peak_index;
  logic [15:0] peak_mag;
  logic [7:0]  peak_exp;
  logic        frame_err;

  fft_mag_peak #(.FFT_LEN(FFT_LEN), .SEARCH_LO(1), .SEARCH_HI(511)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .fft_real(fft_real), .fft_imag(fft_imag), .fft_index(fft_index),
    .blk_exp(blk_exp), .source_valid(source_valid),
    .mag_valid(mag_valid), .mag_data(mag_data), .mag_index(mag_index),
    .busy(busy), .done(done), .peak_index(peak_index), .peak_mag(peak_mag),
    .peak_exp(peak_exp), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    logic [15:0] idx;
    int unsigned cyc;
  } mag_exp_t;

  typedef struct {
    logic [15:0] idx;
    logic [15:0] mag;
    logic [7:0]  bexp;
    logic        err;
    int unsigned cyc;
  } peak_exp_t;

  mag_exp_t  mag_q[$];
  peak_exp_t peak_q[$];
  mag_exp_t  me;
  peak_exp_t pe;
  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference magnitude: max(|re|,|im|) + floor(min/2), computed in plain integers.
  function automatic logic [15:0] ref_mag(input logic signed [15:0] re, input logic signed [15:0] im);
    int ar, ai, hi, lo;
    ar = (re < 0) ? -int'(re) : int'(re);
    ai = (im < 0) ? -int'(im) : int'(im);
    hi = (ar > ai) ? ar : ai;
    lo = (ar > ai) ? ai : ar;
    return 16'(hi + lo / 2);
  endfunction

  // Directed bin contents per test pattern.
  function automatic void stim(input int t, input int i,
                               output logic signed [15:0] re, output logic signed [15:0] im);
    re = '0;
    im = '0;
    case (t)
      1: if (i == 37) begin re = 16'sd1000; im = -16'sd400; end
         else begin re = 16'sd10; im = 16'sd5; end
      2: if (i == 0) re = 16'sd30000;
         else if (i == 900) begin re = 16'sd32767; im = 16'sh8000; end
         else if (i == 1000) begin re = 16'sh8000; im = 16'sh8000; end
      3: if (i == 20 || i == 300) re = 16'sd500;
         else if (i == 700) re = 16'sd9000;
         else if (i == 512) re = 16'sd600;
         else if (i == 0) re = 16'sd20000;
      4: re = 16'sd20000;
      5: if (i == 100) im = -16'sd700;
         else begin re = 16'sd3; im = 16'sd3; end
      6: if (i == 50) re = 16'sd8000; else re = 16'sd2;
      7: if (i == 250) im = 16'sd2000; else begin re = 16'sd1; im = 16'sd1; end
      8: begin re = 16'sd5000; im = 16'sd5000; end
      9: if (i == 511) re = -16'sd300;
         else if (i == 1) re = 16'sd200;
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic signed [15:0] re, input logic signed [15:0] im,
                      input int idx, input logic [7:0] e);
    source_valid = 1'b1;
    fft_real     = re;
    fft_imag     = im;
    fft_index    = 16'(idx);
    blk_exp      = e;
    mag_q.push_back('{ref_mag(re, im), 16'(idx), cyc + 2});
    tick();
    source_valid = 1'b0;
  endtask

  task automatic frame(input int t, input int first, input int last, input logic [7:0] e,
                       input bit gaps, input int start_at, output int unsigned last_cyc);
    logic signed [15:0] re, im;
    last_cyc = 0;
    for (int i = first; i <= last; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          fft_real  = 16'($urandom);
          fft_imag  = 16'($urandom);
          fft_index = 16'($urandom_range(0, 2));
          tick();
        end
      end
      stim(t, i, re, im);
      start = (i == start_at);
      if (i == last) last_cyc = cyc;
      beat(re, im, i, e);
      start = 1'b0;
    end
  endtask

  task automatic expect_peak(input int idx, input int mag, input logic [7:0] e,
                             input logic err, input int unsigned last_cyc);
    peak_q.push_back('{16'(idx), 16'(mag), e, err, last_cyc + 4});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mag_valid"},  mag_valid, 0);
    check({tag, "_mag_data"},   mag_data, 0);
    check({tag, "_mag_index"},  mag_index, 0);
    check({tag, "_busy"},       busy, 0);
    check({tag, "_done"},       done, 0);
    check({tag, "_frame_err"},  frame_err, 0);
    check({tag, "_peak_index"}, peak_index, 0);
    check({tag, "_peak_mag"},   peak_mag, 0);
    check({tag, "_peak_exp"},   peak_exp, 0);
  endtask

  // Monitor: every mag beat and every done pulse must match a queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mag_valid) begin
        if (mag_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mag_spurious actual index=%0d data=%0d required no beat", mag_index, mag_data);
        end else begin
          me = mag_q.pop_front();
          check("mag_data", mag_data, me.data);
          check("mag_index", mag_index, me.idx);
          check("mag_latency_cycle", cyc, me.cyc);
        end
      end
      if (done) begin
        done_seen++;
        if (peak_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_spurious actual done=1 required done=0 (cycle %0d)", cyc);
        end else begin
          pe = peak_q.pop_front();
          check("peak_index", peak_index, pe.idx);
          check("peak_mag", peak_mag, pe.mag);
          check("peak_exp", peak_exp, pe.bexp);
          check("frame_err_at_done", frame_err, pe.err);
          check("done_cycle", cyc, pe.cyc);
          check("busy_at_done", busy, 0);
        end
      end
    end
  end

  int unsigned lc;

  initial begin
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Single tone at bin 37, with an ignored start while busy.
    pulse_start();
    check("busy_after_start", busy, 1);
    frame(1, 0, FFT_LEN - 1, 8'h05, 1'b0, 500, lc);
    expect_peak(37, 1200, 8'h05, 1'b0, lc);
    repeat (8) tick();
    check("busy_idle_after_frame1", busy, 0);

    // Extremes: DC excluded, full-scale beats out of range.
    pulse_start();
    frame(2, 0, FFT_LEN - 1, 8'hF0, 1'b0, -1, lc);
    expect_peak(1, 0, 8'hF0, 1'b0, lc);
    repeat (8) tick();

    // Tie keeps lower bin; bins above SEARCH_HI ignored.
    pulse_start();
    frame(3, 0, FFT_LEN - 1, 8'h03, 1'b0, -1, lc);
    expect_peak(20, 500, 8'h03, 1'b0, lc);
    repeat (8) tick();

    // Start mid-stream waits for the next bin 0.
    frame(4, 400, FFT_LEN - 1, 8'h09, 1'b0, 800, lc);
    check("busy_wait_sof", busy, 1);
    frame(5, 0, FFT_LEN - 1, 8'h11, 1'b0, -1, lc);
    expect_peak(100, 700, 8'h11, 1'b0, lc);
    repeat (8) tick();

    // Frame restart at bin 400, with idle gaps on the source.
    pulse_start();
    frame(6, 0, 399, 8'h04, 1'b1, -1, lc);
    frame(7, 0, FFT_LEN - 1, 8'h04, 1'b1, -1, lc);
    expect_peak(250, 2000, 8'h04, 1'b1, lc);
    repeat (8) tick();
    check("frame_err_sticky", frame_err, 1);

    // Reset in the middle of accumulation aborts the measurement.
    pulse_start();
    check("frame_err_cleared_by_start", frame_err, 0);
    frame(8, 0, 500, 8'h07, 1'b0, -1, lc);
    rst_n = 1'b0;
    #1;
    mag_q.delete();
    check_reset_outputs("midreset");
    tick();
    rst_n = 1'b1;
    tick();
    frame(9, 0, FFT_LEN - 1, 8'h02, 1'b0, -1, lc);
    repeat (6) tick();
    check("no_done_without_start", done_seen, 5);
    pulse_start();
    frame(9, 0, FFT_LEN - 1, 8'h02, 1'b0, -1, lc);
    expect_peak(511, 300, 8'h02, 1'b0, lc);

    for (int k = 0; k < 50 && (mag_q.size() != 0 || peak_q.size() != 0); k++) tick();
    repeat (4) tick();
    check("mag_queue_drained", mag_q.size(), 0);
    check("peak_queue_drained", peak_q.size(), 0);
    check("done_pulse_count", done_seen, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
